// File: rtl/sw_debounce.sv
// Two-flop synchroniser plus per-bit stability counter for raw slide switches.
// An output bit follows its input only after CNT_MAX consecutive stable clocks.
module sw_debounce #(
   parameter int WIDTH   = 4,
   parameter int CNT_MAX = 1000000
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] SW_IN,
   output logic [WIDTH-1:0] SW_OUT,
   output logic             SW_CHG
);

   localparam int CNT_W = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   generate
      if (CNT_MAX < 1) begin : g_badCntMax
         $error("sw_debounce: CNT_MAX must be at least 1");
      end
   endgenerate

   logic [WIDTH-1:0] r_sync1;
   logic [WIDTH-1:0] r_sync2;
   logic [WIDTH-1:0] r_out;
   logic             r_chg;
   logic [CNT_W-1:0] r_cnt [WIDTH];

   logic [WIDTH-1:0] w_outNext;
   logic [WIDTH-1:0] w_upd;
   logic [CNT_W-1:0] w_cntNext [WIDTH];

   // A bit that matches its output holds its counter at zero, so any glitch
   // back to the current level throws away the partial count.
   always_comb begin
      w_outNext = r_out;
      w_upd     = '0;
      for (int i = 0; i < WIDTH; i++) begin
         w_cntNext[i] = '0;
         if (r_sync2[i] != r_out[i]) begin
            if (r_cnt[i] == CNT_LAST) begin
               w_outNext[i] = r_sync2[i];
               w_upd[i]     = 1'b1;
            end else begin
               w_cntNext[i] = r_cnt[i] + CNT_ONE;
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_out   <= '0;
         r_chg   <= 1'b0;
         for (int i = 0; i < WIDTH; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         r_sync1 <= SW_IN;
         r_sync2 <= r_sync1;
         r_out   <= w_outNext;
         r_chg   <= |w_upd;
         for (int i = 0; i < WIDTH; i++) begin
            r_cnt[i] <= w_cntNext[i];
         end
      end
   end

   assign SW_OUT = r_out;
   assign SW_CHG = r_chg;

endmodule
